// File: rtl/sc_player_pkg.sv
// -----------------------------------------------------------------------------
// sc_player_pkg
// Shared definitions for the RoadFighter player-car move controller:
//   - FSM state encoding (IDLE..GAMEOVER), also exported on the state port
//   - shift command codes driven to the position shifter
//   - spawn load code and the shifter's position limits
//   - saturating-decrement helpers for the controller's counters
// -----------------------------------------------------------------------------
package sc_player_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PLAY     = 3'd2,
        ST_CRASH    = 3'd3,
        ST_GAMEOVER = 3'd4
    } ctrlState_t;

    localparam logic [1:0] SHIFT_HOLD  = 2'b00;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    // Load code presented with the load strobe; the shifter maps it to
    // its spawn position (8'h20).
    localparam logic [7:0] SPAWN_CODE = 8'h02;

    // Position limits enforced inside the shifter. The controller never
    // sees the position, so it issues commands regardless of these.
    localparam logic [7:0] POS_LEFT_LIMIT  = 8'h80;
    localparam logic [7:0] POS_RIGHT_LIMIT = 8'h10;

    function automatic logic [2:0] livesDecSat(input logic [2:0] value);
        if (value == 3'd0) begin
            return 3'd0;
        end else begin
            return value - 3'd1;
        end
    endfunction

    function automatic logic [3:0] cooldownDecSat(input logic [3:0] value);
        if (value == 4'd0) begin
            return 4'd0;
        end else begin
            return value - 4'd1;
        end
    endfunction

    function automatic logic [7:0] crashDecSat(input logic [7:0] value);
        if (value == 8'd0) begin
            return 8'd0;
        end else begin
            return value - 8'd1;
        end
    endfunction

endpackage

// File: rtl/sc_player_btnsync.sv
// -----------------------------------------------------------------------------
// sc_player_btnsync
// Two-flop synchronizer plus rising-edge detector for one asynchronous button.
// Ports:
//   SC_RegSHIFTER_P1_CLOCK_50     : system clock
//   SC_RegSHIFTER_P1_RESET_InHigh : asynchronous active-high reset
//   buttonAsync                   : raw button level (asynchronous)
//   buttonLevel                   : synchronized level (2 clocks after input)
//   buttonPulse                   : one-clock pulse, aligned with the cycle in
//                                   which buttonLevel first reads high
// -----------------------------------------------------------------------------
module sc_player_btnsync (
    input  logic SC_RegSHIFTER_P1_CLOCK_50,
    input  logic SC_RegSHIFTER_P1_RESET_InHigh,
    input  logic buttonAsync,
    output logic buttonLevel,
    output logic buttonPulse
);

    logic syncMeta_r;
    logic syncLevel_r;
    logic pulse_r;

    // Synchronizer chain and registered edge detect. The pulse is computed
    // from the first stage against the second, so it rises together with the
    // synchronized level and no extra cycle of latency is added; the second
    // stage itself acts as the edge-detect history.
    always_ff @(posedge SC_RegSHIFTER_P1_CLOCK_50 or posedge SC_RegSHIFTER_P1_RESET_InHigh) begin
        if (SC_RegSHIFTER_P1_RESET_InHigh) begin
            syncMeta_r  <= 1'b0;
            syncLevel_r <= 1'b0;
            pulse_r     <= 1'b0;
        end else begin
            syncMeta_r  <= buttonAsync;
            syncLevel_r <= syncMeta_r;
            pulse_r     <= syncMeta_r & ~syncLevel_r;
        end
    end

    assign buttonLevel = syncLevel_r;
    assign buttonPulse = pulse_r;

endmodule

// File: rtl/sc_player_move_controller.sv
// -----------------------------------------------------------------------------
// sc_player_move_controller
// Sequencing controller for the RoadFighter player-car position shifter.
// Turns synchronized left/right requests, start and crash events into the
// shifter's load strobe, load data and one-clock shift commands, and keeps
// lives and crash/respawn timing.
//
// Parameters:
//   CTRL_LIVES         : lives loaded on start (1..7)
//   CTRL_MOVE_COOLDOWN : ticks between two accepted moves (1..15)
//   CTRL_CRASH_TICKS   : ticks spent in CRASH before respawn/game over (1..255)
// Ports:
//   SC_RegSHIFTER_P1_CLOCK_50         : 50 MHz system clock
//   SC_RegSHIFTER_P1_RESET_InHigh     : asynchronous active-high reset
//   SC_PLAYERCTRL_tick_In             : one-clock game tick strobe
//   SC_PLAYERCTRL_start_In            : start request (level)
//   SC_PLAYERCTRL_crash_In            : collision flag (level)
//   SC_PLAYERCTRL_left_In/right_In    : raw buttons, asynchronous
//   SC_PLAYERCTRL_load_OutLow         : shifter load strobe, active-low
//   SC_PLAYERCTRL_shiftselection_Out  : 01 left, 10 right, 00 hold
//   SC_PLAYERCTRL_data_OutBUS         : shifter load data
//   SC_PLAYERCTRL_state_Out           : FSM state encoding
//   SC_PLAYERCTRL_lives_Out           : remaining lives
// Build option:
//   SC_PLAYERCTRL_AUTOREPEAT_EN : when defined, a held single button requests
//   a move every cycle (repeat rate set by the cooldown); otherwise only a
//   rising edge of the synchronized level is a request.
// All outputs are registered.
// -----------------------------------------------------------------------------
module sc_player_move_controller
    import sc_player_pkg::*;
#(
    parameter int unsigned CTRL_LIVES         = 3,
    parameter int unsigned CTRL_MOVE_COOLDOWN = 2,
    parameter int unsigned CTRL_CRASH_TICKS   = 8
) (
    input  logic       SC_RegSHIFTER_P1_CLOCK_50,
    input  logic       SC_RegSHIFTER_P1_RESET_InHigh,
    input  logic       SC_PLAYERCTRL_tick_In,
    input  logic       SC_PLAYERCTRL_start_In,
    input  logic       SC_PLAYERCTRL_crash_In,
    input  logic       SC_PLAYERCTRL_left_In,
    input  logic       SC_PLAYERCTRL_right_In,
    output logic       SC_PLAYERCTRL_load_OutLow,
    output logic [1:0] SC_PLAYERCTRL_shiftselection_Out,
    output logic [7:0] SC_PLAYERCTRL_data_OutBUS,
    output logic [2:0] SC_PLAYERCTRL_state_Out,
    output logic [2:0] SC_PLAYERCTRL_lives_Out
);

    localparam logic [2:0] LIVES_INIT    = 3'(CTRL_LIVES);
    localparam logic [3:0] COOLDOWN_INIT = 4'(CTRL_MOVE_COOLDOWN);
    localparam logic [7:0] CRASH_INIT    = 8'(CTRL_CRASH_TICKS);

`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
    localparam bit AUTOREPEAT_EN = 1'b1;
`else
    localparam bit AUTOREPEAT_EN = 1'b0;
`endif

    ctrlState_t state_r;
    ctrlState_t nextState_s;

    logic [3:0] cooldown_r;
    logic [7:0] crashCount_r;
    logic [2:0] lives_r;

    logic       loadLow_r;
    logic [1:0] shiftSel_r;
    logic [7:0] data_r;

    logic       loadLow_s;
    logic [1:0] shiftSel_s;
    logic [7:0] data_s;

    logic leftLevel_s;
    logic leftPulse_s;
    logic rightLevel_s;
    logic rightPulse_s;
    logic leftReq_s;
    logic rightReq_s;
    logic moveLeft_s;
    logic moveRight_s;
    logic moveAccept_s;
    logic crashDone_s;

    sc_player_btnsync uLeftSync (
        .SC_RegSHIFTER_P1_CLOCK_50     (SC_RegSHIFTER_P1_CLOCK_50),
        .SC_RegSHIFTER_P1_RESET_InHigh (SC_RegSHIFTER_P1_RESET_InHigh),
        .buttonAsync                   (SC_PLAYERCTRL_left_In),
        .buttonLevel                   (leftLevel_s),
        .buttonPulse                   (leftPulse_s)
    );

    sc_player_btnsync uRightSync (
        .SC_RegSHIFTER_P1_CLOCK_50     (SC_RegSHIFTER_P1_CLOCK_50),
        .SC_RegSHIFTER_P1_RESET_InHigh (SC_RegSHIFTER_P1_RESET_InHigh),
        .buttonAsync                   (SC_PLAYERCTRL_right_In),
        .buttonLevel                   (rightLevel_s),
        .buttonPulse                   (rightPulse_s)
    );

    // Request source: held level in autorepeat builds, edge pulse otherwise.
    // A pulse that arrives while cooldown is running simply expires unused.
    assign leftReq_s  = AUTOREPEAT_EN ? leftLevel_s  : leftPulse_s;
    assign rightReq_s = AUTOREPEAT_EN ? rightLevel_s : rightPulse_s;

    // The crash phase ends on the tick that takes the counter to zero
    // (the zero test only guards against an out-of-range parameter).
    assign crashDone_s = (crashCount_r == 8'd0) ||
                         (SC_PLAYERCTRL_tick_In && (crashCount_r == 8'd1));

    // Move decision: only in PLAY, only with cooldown expired, and crash wins
    // over any move. Both directions at once cancel each other.
    always_comb begin
        moveLeft_s  = 1'b0;
        moveRight_s = 1'b0;
        if ((state_r == ST_PLAY) && !SC_PLAYERCTRL_crash_In && (cooldown_r == 4'd0)) begin
            if (leftReq_s && !rightReq_s) begin
                moveLeft_s = 1'b1;
            end else if (rightReq_s && !leftReq_s) begin
                moveRight_s = 1'b1;
            end else begin
                moveLeft_s  = 1'b0;
                moveRight_s = 1'b0;
            end
        end else begin
            moveLeft_s  = 1'b0;
            moveRight_s = 1'b0;
        end
    end

    assign moveAccept_s = moveLeft_s | moveRight_s;

    // FSM state register.
    always_ff @(posedge SC_RegSHIFTER_P1_CLOCK_50 or posedge SC_RegSHIFTER_P1_RESET_InHigh) begin
        if (SC_RegSHIFTER_P1_RESET_InHigh) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (SC_PLAYERCTRL_start_In) begin
                    nextState_s = ST_LOAD;
                end else begin
                    nextState_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                nextState_s = ST_PLAY;
            end
            ST_PLAY: begin
                if (SC_PLAYERCTRL_crash_In) begin
                    nextState_s = ST_CRASH;
                end else begin
                    nextState_s = ST_PLAY;
                end
            end
            ST_CRASH: begin
                if (crashDone_s) begin
                    if (lives_r != 3'd0) begin
                        nextState_s = ST_LOAD;
                    end else begin
                        nextState_s = ST_GAMEOVER;
                    end
                end else begin
                    nextState_s = ST_CRASH;
                end
            end
            ST_GAMEOVER: begin
                if (SC_PLAYERCTRL_start_In) begin
                    nextState_s = ST_LOAD;
                end else begin
                    nextState_s = ST_GAMEOVER;
                end
            end
            default: begin
                nextState_s = ST_IDLE;
            end
        endcase
    end

    // FSM output decode. Decoding from the next state lets the registered
    // load strobe line up with the cycle in which state reads LOAD.
    always_comb begin
        loadLow_s  = 1'b1;
        data_s     = 8'h00;
        shiftSel_s = SHIFT_HOLD;
        if (nextState_s == ST_LOAD) begin
            loadLow_s = 1'b0;
            data_s    = SPAWN_CODE;
        end else begin
            loadLow_s = 1'b1;
            data_s    = 8'h00;
        end
        if (moveLeft_s) begin
            shiftSel_s = SHIFT_LEFT;
        end else if (moveRight_s) begin
            shiftSel_s = SHIFT_RIGHT;
        end else begin
            shiftSel_s = SHIFT_HOLD;
        end
    end

    // Output registers.
    always_ff @(posedge SC_RegSHIFTER_P1_CLOCK_50 or posedge SC_RegSHIFTER_P1_RESET_InHigh) begin
        if (SC_RegSHIFTER_P1_RESET_InHigh) begin
            loadLow_r  <= 1'b1;
            shiftSel_r <= SHIFT_HOLD;
            data_r     <= 8'h00;
        end else begin
            loadLow_r  <= loadLow_s;
            shiftSel_r <= shiftSel_s;
            data_r     <= data_s;
        end
    end

    // Cooldown, crash counter and lives. A move reloads the cooldown even if
    // a tick arrives in the same clock; a crash discards the cooldown.
    always_ff @(posedge SC_RegSHIFTER_P1_CLOCK_50 or posedge SC_RegSHIFTER_P1_RESET_InHigh) begin
        if (SC_RegSHIFTER_P1_RESET_InHigh) begin
            cooldown_r   <= 4'd0;
            crashCount_r <= 8'd0;
            lives_r      <= LIVES_INIT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cooldown_r   <= 4'd0;
                    crashCount_r <= 8'd0;
                    lives_r      <= LIVES_INIT;
                end
                ST_LOAD: begin
                    cooldown_r <= 4'd0;
                end
                ST_PLAY: begin
                    if (SC_PLAYERCTRL_crash_In) begin
                        cooldown_r   <= 4'd0;
                        crashCount_r <= CRASH_INIT;
                        lives_r      <= livesDecSat(lives_r);
                    end else if (moveAccept_s) begin
                        cooldown_r <= COOLDOWN_INIT;
                    end else if (SC_PLAYERCTRL_tick_In) begin
                        cooldown_r <= cooldownDecSat(cooldown_r);
                    end else begin
                        cooldown_r <= cooldown_r;
                    end
                end
                ST_CRASH: begin
                    if (SC_PLAYERCTRL_tick_In) begin
                        crashCount_r <= crashDecSat(crashCount_r);
                    end else begin
                        crashCount_r <= crashCount_r;
                    end
                end
                ST_GAMEOVER: begin
                    if (SC_PLAYERCTRL_start_In) begin
                        lives_r <= LIVES_INIT;
                    end else begin
                        lives_r <= lives_r;
                    end
                end
                default: begin
                    cooldown_r   <= 4'd0;
                    crashCount_r <= 8'd0;
                end
            endcase
        end
    end

    assign SC_PLAYERCTRL_load_OutLow        = loadLow_r;
    assign SC_PLAYERCTRL_shiftselection_Out = shiftSel_r;
    assign SC_PLAYERCTRL_data_OutBUS        = data_r;
    assign SC_PLAYERCTRL_state_Out          = state_r;
    assign SC_PLAYERCTRL_lives_Out          = lives_r;

endmodule

// File: tb/tb_sc_player_move_controller.sv
// -----------------------------------------------------------------------------
// tb_sc_player_move_controller
// Self-checking bench: a directed walk through start, moves, cooldown, both
// buttons, crash priority, respawn, game over and restart, followed by a long
// randomized run. Every clock the DUT outputs are compared against a
// behavioural model that follows the controller's rules on plain integers.
// -----------------------------------------------------------------------------
module tb_sc_player_move_controller;

    localparam int LIVES  = 3;
    localparam int COOL   = 2;
    localparam int CTICKS = 8;

    // Spec-level state numbering
    localparam int S_IDLE = 0, S_LOAD = 1, S_PLAY = 2, S_CRASH = 3, S_OVER = 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       tick  = 1'b0;
    logic       start = 1'b0;
    logic       crash = 1'b0;
    logic       left  = 1'b0;
    logic       right = 1'b0;
    logic       loadLow;
    logic [1:0] shiftSel;
    logic [7:0] dataBus;
    logic [2:0] state;
    logic [2:0] lives;

    always #10 clk = ~clk;

    sc_player_move_controller #(
        .CTRL_LIVES         (LIVES),
        .CTRL_MOVE_COOLDOWN (COOL),
        .CTRL_CRASH_TICKS   (CTICKS)
    ) dut (
        .SC_RegSHIFTER_P1_CLOCK_50        (clk),
        .SC_RegSHIFTER_P1_RESET_InHigh    (rst),
        .SC_PLAYERCTRL_tick_In            (tick),
        .SC_PLAYERCTRL_start_In           (start),
        .SC_PLAYERCTRL_crash_In           (crash),
        .SC_PLAYERCTRL_left_In            (left),
        .SC_PLAYERCTRL_right_In           (right),
        .SC_PLAYERCTRL_load_OutLow        (loadLow),
        .SC_PLAYERCTRL_shiftselection_Out (shiftSel),
        .SC_PLAYERCTRL_data_OutBUS        (dataBus),
        .SC_PLAYERCTRL_state_Out          (state),
        .SC_PLAYERCTRL_lives_Out          (lives)
    );

    int checksRun    = 0;
    int checksPassed = 0;

    // Model state
    int mSt, mLives, mCool, mCrashTicks;
    bit lHist [4];
    bit rHist [4];
    int eState, eLives, eLoadLow, eShift, eData;

    int cyc       = 0;
    int shiftSeen = 0;
    int loadSeen  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input int exp);
        checksRun++;
        if (got === 32'(exp)) begin
            checksPassed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Predict the outputs after the coming clock edge from current inputs.
    task automatic modelStep();
        bit reqL, reqR;
        int nst;
        if (rst) begin
            mSt = S_IDLE; mLives = LIVES; mCool = 0; mCrashTicks = 0;
            for (int i = 0; i < 4; i++) begin
                lHist[i] = 1'b0;
                rHist[i] = 1'b0;
            end
            eState = S_IDLE; eLives = LIVES; eLoadLow = 1; eShift = 0; eData = 0;
            return;
        end
        // Button seen by the decision = raw input two clocks back.
        for (int i = 3; i > 0; i--) begin
            lHist[i] = lHist[i-1];
            rHist[i] = rHist[i-1];
        end
        lHist[0] = left;
        rHist[0] = right;
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
        reqL = lHist[2];
        reqR = rHist[2];
`else
        reqL = lHist[2] && !lHist[3];
        reqR = rHist[2] && !rHist[3];
`endif
        eShift = 0;
        nst    = mSt;
        case (mSt)
            S_IDLE: begin
                mLives = LIVES;
                mCool  = 0;
                if (start) nst = S_LOAD;
            end
            S_LOAD: begin
                mCool = 0;
                nst   = S_PLAY;
            end
            S_PLAY: begin
                if (crash) begin
                    mLives      = (mLives > 0) ? mLives - 1 : 0;
                    mCrashTicks = CTICKS;
                    mCool       = 0;
                    nst         = S_CRASH;
                end else if (mCool == 0 && (reqL != reqR)) begin
                    eShift = reqL ? 1 : 2;
                    mCool  = COOL;
                end else if (tick && mCool > 0) begin
                    mCool = mCool - 1;
                end
            end
            S_CRASH: begin
                if (tick) begin
                    mCrashTicks = mCrashTicks - 1;
                    if (mCrashTicks == 0) nst = (mLives != 0) ? S_LOAD : S_OVER;
                end
            end
            S_OVER: begin
                if (start) begin
                    mLives = LIVES;
                    nst    = S_LOAD;
                end
            end
            default: nst = S_IDLE;
        endcase
        eLoadLow = (nst == S_LOAD) ? 0 : 1;
        eData    = (nst == S_LOAD) ? 2 : 0;
        mSt      = nst;
        eState   = mSt;
        eLives   = mLives;
    endtask

    // One clock: predict, pass the rising edge, compare on the falling edge.
    task automatic doCycle();
        modelStep();
        @(negedge clk);
        cyc++;
        checkVal("state", state, eState);
        checkVal("lives", lives, eLives);
        checkVal("load_n", loadLow, eLoadLow);
        checkVal("shiftsel", shiftSel, eShift);
        checkVal("data", dataBus, eData);
        if (shiftSel != 2'b00) shiftSeen++;
        if (loadLow == 1'b0) loadSeen++;
    endtask

    // Run n clocks with a tick every fourth clock.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick = ((cyc % 4) == 0);
            doCycle();
        end
        tick = 1'b0;
    endtask

    int expRepeat;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        doCycle();
        doCycle();
        rst = 1'b0;
        checkVal("rst_state", state, S_IDLE);
        checkVal("rst_lives", lives, LIVES);
        checkVal("rst_load_n", loadLow, 1);
        run(3);

        // Start: one LOAD clock with spawn code, then PLAY
        start = 1'b1;
        doCycle();
        start = 1'b0;
        checkVal("start_load_n", loadLow, 0);
        checkVal("start_data", dataBus, 8'h02);
        doCycle();
        checkVal("start_play", state, S_PLAY);
        checkVal("start_lives", lives, LIVES);

        // Single left move, 3 clocks after the edge, exactly one pulse
        shiftSeen = 0;
        left = 1'b1;
        doCycle(); doCycle(); doCycle();
        checkVal("move_latency", shiftSel, 1);
        left = 1'b0;
        repeat (3) doCycle();
        checkVal("move_once", shiftSeen, 1);

        // Second press with no ticks elapsed: cooldown still running
        shiftSeen = 0;
        left = 1'b1;
        repeat (4) doCycle();
        left = 1'b0;
        repeat (2) doCycle();
        checkVal("cooldown_drop", shiftSeen, 0);
        run(12);

        // Both buttons together: no command
        shiftSeen = 0;
        left = 1'b1; right = 1'b1;
        repeat (4) doCycle();
        left = 1'b0; right = 1'b0;
        repeat (2) doCycle();
        checkVal("both_none", shiftSeen, 0);
        run(8);

        // Crash coincides with a right request
        right = 1'b1;
        doCycle(); doCycle();
        crash = 1'b1;
        doCycle();
        crash = 1'b0;
        right = 1'b0;
        checkVal("crash_state", state, S_CRASH);
        checkVal("crash_noshift", shiftSel, 0);
        checkVal("crash_lives", lives, LIVES - 1);
        loadSeen = 0;
        run(40);
        checkVal("respawn_load", loadSeen, 1);
        checkVal("respawn_play", state, S_PLAY);

        // Two more crashes: game over
        repeat (2) begin
            crash = 1'b1;
            doCycle();
            crash = 1'b0;
            run(40);
        end
        checkVal("over_state", state, S_OVER);
        checkVal("over_lives", lives, 0);
        start = 1'b1;
        doCycle();
        start = 1'b0;
        checkVal("restart_lives", lives, LIVES);
        checkVal("restart_load_n", loadLow, 0);
        doCycle();
        run(8);

        // Hold right across 10 ticks
        shiftSeen = 0;
        right = 1'b1;
        doCycle(); doCycle();
        for (int i = 0; i < 10; i++) begin
            tick = 1'b1;
            doCycle();
            tick = 1'b0;
            doCycle(); doCycle(); doCycle();
        end
`ifdef SC_PLAYERCTRL_AUTOREPEAT_EN
        expRepeat = 5;
`else
        expRepeat = 1;
`endif
        checkVal("hold_pulses", shiftSeen, expRepeat);
        right = 1'b0;
        run(8);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            tick  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) left  = ~left;
            if ($urandom_range(0, 5) == 0) right = ~right;
            start = ($urandom_range(0, 39) == 0);
            crash = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 999) == 0);
            doCycle();
        end
        rst = 1'b0; tick = 1'b0; start = 1'b0; crash = 1'b0;
        doCycle();

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule

// File: doc/sc_player_move_controller.md
# sc_player_move_controller

Sequencing controller for the player-car position shifter in RoadFighter. It turns debounced left/right requests, game-start and crash events into the shifter's load strobe, load data and one-cycle shift commands. It also keeps the lives count and the crash/respawn timing. The controller sits between the input/game-logic layer and the position shifter, and is the only driver of the shifter's control inputs.

## Interface
- `CTRL_LIVES`, default 3: lives loaded on start (1..7).
- `CTRL_MOVE_COOLDOWN`, default 2: ticks between two accepted moves (1..15).
- `CTRL_CRASH_TICKS`, default 8: ticks spent in CRASH before respawn/game-over (1..255).
- `SC_RegSHIFTER_P1_CLOCK_50`, input, 1: system clock, 50 MHz.
- `SC_RegSHIFTER_P1_RESET_InHigh`, input, 1: reset, asynchronous, active-high.
- `SC_PLAYERCTRL_tick_In`, input, 1: game-tick strobe, one clock wide.
- `SC_PLAYERCTRL_start_In`, input, 1: start request, level.
- `SC_PLAYERCTRL_crash_In`, input, 1: collision flag from game logic, level.
- `SC_PLAYERCTRL_left_In`, input, 1: left button, active-high, asynchronous.
- `SC_PLAYERCTRL_right_In`, input, 1: right button, active-high, asynchronous.
- `SC_PLAYERCTRL_load_OutLow`, output, 1: shifter load strobe, active-low.
- `SC_PLAYERCTRL_shiftselection_Out`, output, 2: shift command to the shifter. 01 = left, 10 = right, 00 = hold.
- `SC_PLAYERCTRL_data_OutBUS`, output, 8: shifter load data.
- `SC_PLAYERCTRL_state_Out`, output, 3: FSM state encoding.
- `SC_PLAYERCTRL_lives_Out`, output, 3: remaining lives.

## Operation
- **Button synchronisation:** left and right each pass through a 2-flop synchronizer.
- **FSM states:** IDLE=0, LOAD=1, PLAY=2, CRASH=3, GAMEOVER=4.
- **IDLE:**
  - On start=1, go to LOAD.
  - lives ← `CTRL_LIVES`.
- **LOAD:**
  - Lasts exactly one clock.
  - load_OutLow=0 and data_OutBUS=8'h02; the shifter places the car at 8'h20.
  - Next state is PLAY.
  - cooldown ← 0.
  - Edge-detect history ← current synchronized levels.
- **PLAY:**
  - crash=1 → CRASH. Crash has priority over any move in the same cycle.
  - On crash, lives ← lives−1 (saturate at 0) and crash counter ← `CTRL_CRASH_TICKS`.
  - A move is accepted when cooldown==0 and exactly one direction is requested.
  - An accepted move drives shiftselection for exactly one clock: 01 for left, 10 for right.
  - An accepted move sets cooldown ← `CTRL_MOVE_COOLDOWN`.
  - If both directions are requested: no move, and the requests are consumed.
  - Cooldown decrements on tick and saturates at 0.
  - Edge limits (left limit 8'h80, right limit 8'h10) are enforced by the shifter. The controller still issues the command, and cooldown is still loaded.
- **CRASH:**
  - The crash counter decrements on each tick.
  - When the counter reaches 0: lives≠0 → LOAD (respawn); lives==0 → GAMEOVER.
- **GAMEOVER:**
  - On start=1, lives ← `CTRL_LIVES` and go to LOAD.
- **Outside LOAD:** load_OutLow=1 and data_OutBUS=8'h00.
- **Outside accepted-move cycles:** shiftselection=00.

## Timing
- **Reset values:** load_OutLow=1, shiftselection=00, data_OutBUS=00, state=IDLE, lives=`CTRL_LIVES`. All counters are 0.
- **Reset mid-operation:** returns to IDLE immediately. Any pending move is dropped.
- **Outputs:** all outputs are registered.
- **Start latency:** start sampled high in IDLE gives load_OutLow=0 on the next clock. PLAY follows one clock after that.
- **Button latency:** a button edge produces shiftselection 3 clocks later (2 synchronizer clocks + 1 decision register), provided cooldown==0.
- **Tick during a move cycle:** tick and an accepted move in the same clock load cooldown; no decrement happens that clock.
- **Crash during cooldown:** the transition to CRASH still happens; cooldown state is discarded.
- **Lives width:** 3 bits, so `CTRL_LIVES` must be ≤7.
- **Crash counter width:** 8 bits.

## Configuration
- **`SC_PLAYERCTRL_AUTOREPEAT_EN` defined:** a held single button is a request every cycle. It therefore repeats a move every `CTRL_MOVE_COOLDOWN` ticks.
- **`SC_PLAYERCTRL_AUTOREPEAT_EN` undefined:**
  - Only a rising edge of the synchronized level is a request: one move per press.
  - An edge arriving while cooldown≠0 is discarded, not queued.

## Structure
- **Shared package `sc_player_pkg`:**
  - State encodings IDLE..GAMEOVER.
  - Shift codes SHIFT_HOLD=2'b00, SHIFT_LEFT=2'b01, SHIFT_RIGHT=2'b10.
  - Load constant SPAWN_CODE=8'h02.
  - Position limits 8'h80 and 8'h10.
- **Sub-module `sc_player_btnsync`:** one instance per button. It contains the 2-flop synchronizer plus the rising-edge detector, and outputs both level and pulse.
- **Main module:** the FSM, cooldown counter, crash counter and lives register.

## Test plan
- **Start to load:** reset, then start=1 for 1 clock → state IDLE→LOAD→PLAY. load_OutLow=0 for exactly 1 clock with data_OutBUS=8'h02. lives=3.
- **Single move:** in PLAY, left pulse (cooldown 0) → shiftselection=01 for exactly 1 clock, 3 clocks after the edge. A second left press within 2 ticks → no command.
- **Both buttons:** left and right pressed in the same clock → shiftselection stays 00.
- **Crash priority and respawn:** crash=1 coinciding with a right request → state=CRASH, no shift command, lives 3→2. After 8 ticks → LOAD strobe, then PLAY.
- **Game over and restart:** three crash cycles → after the third, state=GAMEOVER and lives=0. start=1 → lives=3, LOAD.
- **Autorepeat (macro on):** hold right for 10 ticks with COOLDOWN=2 → shiftselection=10 pulses at ticks 0, 2, 4, 6, 8. With the macro off → exactly 1 pulse.
